// File: rtl/alu_operand_buffer.sv
// -----------------------------------------------------------------------------
// alu_operand_buffer
//
// Two-entry registered skid buffer between decode/issue and the ALU. Decode
// pushes an operand pair plus opcode; the ALU pops the head entry. A stall on
// the ALU side is absorbed by the skid entry, so nothing is lost. Both
// handshakes are fully registered: i_in_ready and all o_out_* outputs depend
// only on flops.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous flush, drops every held entry
//   i_in_valid   producer presents i_in_a / i_in_b / i_in_op
//   o_in_ready   buffer accepts an entry this cycle (not FULL)
//   i_in_a/b     operands A and B
//   i_in_op      ALU opcode
//   o_out_valid  head entry valid (not EMPTY)
//   i_out_ready  ALU consumes the head entry this cycle
//   o_out_a/b    head operands (registered)
//   o_out_op     head opcode (registered)
//   o_occupancy  entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module alu_operand_buffer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    input  logic [OP_W-1:0]   i_in_op,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_a,
    output logic [DATA_W-1:0] o_out_b,
    output logic [OP_W-1:0]   o_out_op,
    output logic [1:0]        o_occupancy
);

    // The state encoding is the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_head_a;
    logic [DATA_W-1:0]   r_head_b;
    logic [OP_W-1:0]     r_head_op;
    logic [DATA_W-1:0]   r_skid_a;
    logic [DATA_W-1:0]   r_skid_b;
    logic [OP_W-1:0]     r_skid_op;

    logic                w_push;
    logic                w_pop;
    logic                w_head_from_in;
    logic                w_head_from_skid;
    logic                w_skid_from_in;

    assign o_in_ready  = (r_state != FULL);
    assign o_out_valid = (r_state != EMPTY);
    assign o_occupancy = r_state;
    assign o_out_a     = r_head_a;
    assign o_out_b     = r_head_b;
    assign o_out_op    = r_head_op;

    assign w_push = i_in_valid & o_in_ready;
    assign w_pop  = o_out_valid & i_out_ready;

    // Next-state and data-register load selects.
    always_comb begin
        w_state_next     = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;

        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_head_from_in = 1'b1;
                    w_state_next   = ONE;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    // Full throughput: new entry replaces the consumed head.
                    w_head_from_in = 1'b1;
                end else if (w_push) begin
                    w_skid_from_in = 1'b1;
                    w_state_next   = FULL;
                end else if (w_pop) begin
                    w_state_next   = EMPTY;
                end
            end
            FULL: begin
                // No push possible here since o_in_ready is low.
                if (w_pop) begin
                    w_head_from_skid = 1'b1;
                    w_state_next     = ONE;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase

        // Flush wins over everything; a same-cycle input is discarded, while a
        // same-cycle pop has already been consumed by the ALU.
        if (i_flush) begin
            w_state_next     = EMPTY;
            w_head_from_in   = 1'b0;
            w_head_from_skid = 1'b0;
            w_skid_from_in   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data registers keep their last value when not loaded (not cleared on pop).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head_a  <= '0;
            r_head_b  <= '0;
            r_head_op <= '0;
        end else if (w_head_from_in) begin
            r_head_a  <= i_in_a;
            r_head_b  <= i_in_b;
            r_head_op <= i_in_op;
        end else if (w_head_from_skid) begin
            r_head_a  <= r_skid_a;
            r_head_b  <= r_skid_b;
            r_head_op <= r_skid_op;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_a  <= '0;
            r_skid_b  <= '0;
            r_skid_op <= '0;
        end else if (w_skid_from_in) begin
            r_skid_a  <= i_in_a;
            r_skid_b  <= i_in_b;
            r_skid_op <= i_in_op;
        end
    end

endmodule

// File: tb/tb_alu_operand_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_buffer
//
// Directed tests plus a random soak. Accepted entries are captured from the
// input bus into a scoreboard queue; an independent monitor pops and compares
// every time the DUT presents a consumed output, and also checks occupancy,
// handshake flags and output stability during stalls.
// -----------------------------------------------------------------------------
module tb_alu_operand_buffer;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [OP_W-1:0]   out_op;
    logic [1:0]        occupancy;

    int errors = 0;
    int checks = 0;
    ent_t sb[$];

    alu_operand_buffer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_op     (in_op),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_a     (out_a),
        .o_out_b     (out_b),
        .o_out_op    (out_op),
        .o_occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] a);
        in_valid = v;
        in_a     = a;
        in_b     = a + 32'd100;
        in_op    = a[OP_W-1:0];
    endtask

    // Feeder: capture the handshake at mid-cycle, apply it to the scoreboard
    // at the edge the DUT commits it.
    initial begin : feeder
        logic c_rst, c_flush, c_push;
        ent_t e;
        forever begin
            @(negedge clk);
            c_rst   = !rst_n;
            c_flush = flush;
            c_push  = in_valid && in_ready;
            e.a     = in_a;
            e.b     = in_b;
            e.op    = in_op;
            @(posedge clk);
            if (c_rst || c_flush) sb.delete();
            else if (c_push) sb.push_back(e);
        end
    end

    // Monitor: independent of stimulus.
    initial begin : monitor
        logic              prev_hold;
        logic [DATA_W-1:0] prev_a, prev_b;
        logic [OP_W-1:0]   prev_op;
        ent_t              e;
        prev_hold = 1'b0;
        prev_a = '0; prev_b = '0; prev_op = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                chk("occupancy", 64'(occupancy), 64'(sb.size()));
                chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
                chk("in_ready",  64'(in_ready),  64'(sb.size() != 2));
                if (prev_hold && out_valid) begin
                    chk("stall_stable_a",  64'(out_a),  64'(prev_a));
                    chk("stall_stable_b",  64'(out_b),  64'(prev_b));
                    chk("stall_stable_op", 64'(out_op), 64'(prev_op));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("pop_with_empty_scoreboard", 64'(out_a), 64'hDEAD_BEEF_DEAD_BEEF);
                    end else begin
                        e = sb.pop_front();
                        chk("pop_a",  64'(out_a),  64'(e.a));
                        chk("pop_b",  64'(out_b),  64'(e.b));
                        chk("pop_op", 64'(out_op), 64'(e.op));
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_a    = out_a;
                prev_b    = out_b;
                prev_op   = out_op;
            end
        end
    end

    initial begin : stimulus
        logic [DATA_W-1:0] cnt;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        step(); step();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_out_a",     64'(out_a),     64'd0);
        rst_n = 1'b1;

        // Streaming: one per cycle, visible one cycle after push.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i));
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_a",     64'(out_a),     64'(i));
            chk("stream_op",    64'(out_op),    64'(i % 16));
        end
        drive(1'b0, '0);
        step(); step();
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Stall: 5 and 6 fill the buffer.
        out_ready = 1'b0;
        drive(1'b1, 32'd5); step();
        drive(1'b1, 32'd6); step();
        chk("stall_occupancy", 64'(occupancy), 64'd2);
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        chk("stall_out_a",     64'(out_a),     64'd5);

        // Full-hold: 7 offered but refused while full.
        drive(1'b1, 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fullhold_out_a",    64'(out_a),    64'd5);
            chk("fullhold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();                                  // pop 5
        chk("drain_head_6",   64'(out_a),    64'd6);
        chk("drain_ready",    64'(in_ready), 64'd1);
        step();                                  // pop 6, push 7
        chk("drain_head_7",   64'(out_a),     64'd7);
        chk("drain_occ_one",  64'(occupancy), 64'd1);
        drive(1'b0, '0);
        step();                                  // pop 7
        chk("drain_empty",    64'(out_valid), 64'd0);

        // Flush from FULL with 9 offered.
        out_ready = 1'b0;
        drive(1'b1, 32'd5); step();
        drive(1'b1, 32'd6); step();
        drive(1'b1, 32'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        chk("flush_full_occ",   64'(occupancy), 64'd0);
        chk("flush_full_valid", 64'(out_valid), 64'd0);

        // Flush from ONE while 9 is actually handshaken: must be discarded.
        drive(1'b1, 32'd5); step();
        drive(1'b1, 32'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        chk("flush_one_occ",   64'(occupancy), 64'd0);
        chk("flush_one_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        step(); step();

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'd5); step();
        drive(1'b1, 32'd6); step();
        drive(1'b0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",    64'(out_valid), 64'd0);
        chk("async_rst_occ",      64'(occupancy), 64'd0);
        chk("async_rst_out_a",    64'(out_a),     64'd0);
        chk("async_rst_in_ready", 64'(in_ready),  64'd1);
        step(); step();
        rst_n = 1'b1;
        drive(1'b1, 32'd11);
        step();
        chk("post_rst_first_push", 64'(out_a),     64'd11);
        chk("post_rst_valid",      64'(out_valid), 64'd1);
        drive(1'b0, '0);
        out_ready = 1'b1;
        step(); step();

        // Random soak.
        cnt = 32'd1000;
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), cnt);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            cnt++;
            step();
        end
        flush = 1'b0;
        drive(1'b0, '0);
        out_ready = 1'b1;
        step(); step(); step(); step();
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_occupancy",        64'(occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
